// File: rtl/swap_engine_pkg.sv
// Shared types for the register-swap engine: FSM states, step codes, sizing.
package swap_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3
  } state_e;

  localparam logic [2:0] STEP_NONE = 3'b000;
  localparam logic [2:0] STEP_TMP  = 3'b001;
  localparam logic [2:0] STEP_A    = 3'b010;
  localparam logic [2:0] STEP_B    = 3'b100;

  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic idx_ok(input int idx, input int n);
    return idx < n;
  endfunction

endpackage

// File: rtl/swap_engine_regfile.sv
// NREGS x WIDTH register file: one sync write port, three async read ports.
module swap_engine_regfile
  import swap_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = aw_of(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && idx_ok(int'(waddr), NREGS))
      mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Holes above NREGS read as zero
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    rd_data = '0;
    if (idx_ok(int'(ra_addr), NREGS))
      ra_data = mem_q[ra_addr];
    if (idx_ok(int'(rb_addr), NREGS))
      rb_data = mem_q[rb_addr];
    if (idx_ok(int'(rd_addr), NREGS))
      rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/swap_engine.sv
// Register-swap engine: exchanges R[a] and R[b] through tmp in three steps.
// Optional SWAP_SKIP_SAME_EN: a==b jumps straight to a silent final step.
module swap_engine
  import swap_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = aw_of(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic [AW-1:0]    sel_a,
  input  logic [AW-1:0]    sel_b,
  input  logic             ld,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       step,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [AW-1:0]    b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic             err_q, err_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;

  swap_engine_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .ra_addr(a_q),
    .ra_data(ra_data),
    .rb_addr(b_q),
    .rb_data(rb_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tmp_d   = tmp_q;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = ld_addr;
    wdata   = ld_data;
    step    = STEP_NONE;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld) begin
          if (idx_ok(int'(ld_addr), NREGS)) we = 1'b1;
          else err_d = 1'b1;
        end
        if (w) begin
          if (idx_ok(int'(sel_a), NREGS) &&
              idx_ok(int'(sel_b), NREGS)) begin
            a_d     = sel_a;
            b_d     = sel_b;
            state_d = ST_S1;
`ifdef SWAP_SKIP_SAME_EN
            if (sel_a == sel_b) state_d = ST_S3;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_S1: begin
        step    = STEP_TMP;
        tmp_d   = ra_data;
        state_d = ST_S2;
      end
      ST_S2: begin
        step    = STEP_A;
        we      = 1'b1;
        waddr   = a_q;
        wdata   = rb_data;
        state_d = ST_S3;
      end
      ST_S3: begin
        done    = 1'b1;
        waddr   = b_q;
        wdata   = tmp_q;
        state_d = ST_IDLE;
`ifdef SWAP_SKIP_SAME_EN
        if (a_q != b_q) begin
          we   = 1'b1;
          step = STEP_B;
        end
`else
        we   = 1'b1;
        step = STEP_B;
`endif
      end
    endcase
    busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tmp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_swap_engine.sv
// Directed bench for swap_engine (NREGS=5, WIDTH=8).
module tb_swap_engine;

  localparam int WIDTH = 8;
  localparam int NREGS = 5;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             w = 1'b0;
  logic [AW-1:0]    sel_a = '0;
  logic [AW-1:0]    sel_b = '0;
  logic             ld = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic [2:0]       step;
  logic             busy;
  logic             done;
  logic             err;

  int n_chk = 0;
  int n_err = 0;

  swap_engine #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .w      (w),
    .sel_a  (sel_a),
    .sel_b  (sel_b),
    .ld     (ld),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .step   (step),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag,
                        input int addr,
                        input logic [7:0] exp);
    rd_addr = AW'(addr);
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic load(input int addr, input logic [7:0] data);
    ld = 1'b1;
    ld_addr = AW'(addr);
    ld_data = data;
    tick();
    ld = 1'b0;
  endtask

  task automatic swap(input int a, input int b);
    w = 1'b1;
    sel_a = AW'(a);
    sel_b = AW'(b);
    tick();
    w = 1'b0;
    repeat (3) tick();
  endtask

  logic [AW-1:0] pa [4];
  logic [AW-1:0] pb [4];
  int n_acc;
  int pi;
  int cnt;

  initial begin
    pa[0] = 3'd0; pb[0] = 3'd1;
    pa[1] = 3'd1; pb[1] = 3'd2;
    pa[2] = 3'd0; pb[2] = 3'd2;
    pa[3] = 3'd3; pb[3] = 3'd4;

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    for (int i = 0; i < NREGS; i++) rd_chk("rst_reg", i, 8'h00);

    load(0, 8'h11);
    load(1, 8'h22);
    chk("ld_err", 32'(err), 32'd0);
    w = 1'b1; sel_a = 3'd0; sel_b = 3'd1;
    tick();
    w = 1'b0;
    chk("s1_step", 32'(step), 32'b001);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_done", 32'(done), 32'd0);
    tick();
    chk("s2_step", 32'(step), 32'b010);
    chk("s2_done", 32'(done), 32'd0);
    tick();
    chk("s3_step", 32'(step), 32'b100);
    chk("s3_done", 32'(done), 32'd1);
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd0);
    rd_chk("swap_r0", 0, 8'h22);
    rd_chk("swap_r1", 1, 8'h11);
    rd_chk("oor_rd5", 5, 8'h00);
    rd_chk("oor_rd7", 7, 8'h00);

    w = 1'b1; sel_a = 3'd6; sel_b = 3'd0;
    tick();
    w = 1'b0;
    chk("bad_sel_err", 32'(err), 32'd1);
    chk("bad_sel_busy", 32'(busy), 32'd0);
    tick();
    chk("bad_sel_err_clr", 32'(err), 32'd0);
    chk("bad_sel_busy2", 32'(busy), 32'd0);
    load(7, 8'hFF);
    chk("bad_ld_err", 32'(err), 32'd1);
    tick();
    chk("bad_ld_err_clr", 32'(err), 32'd0);
    rd_chk("bad_r0", 0, 8'h22);
    rd_chk("bad_r1", 1, 8'h11);
    for (int i = 2; i < NREGS; i++) rd_chk("bad_rx", i, 8'h00);

    load(2, 8'hA5);
    w = 1'b1; sel_a = 3'd2; sel_b = 3'd2;
    tick();
    w = 1'b0;
    cnt = 1;
    while (!done && cnt < 10) begin
      tick();
      cnt++;
    end
`ifdef SWAP_SKIP_SAME_EN
    chk("same_lat", 32'(cnt), 32'd1);
    chk("same_step", 32'(step), 32'b000);
`else
    chk("same_lat", 32'(cnt), 32'd3);
    chk("same_step", 32'(step), 32'b100);
`endif
    tick();
    chk("same_busy", 32'(busy), 32'd0);
    rd_chk("same_r2", 2, 8'hA5);

    load(3, 8'h33);
    w = 1'b1; sel_a = 3'd0; sel_b = 3'd3;
    tick();
    w = 1'b0;
    tick();
    chk("pre_rst_step", 32'(step), 32'b010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_step", 32'(step), 32'd0);
    for (int i = 0; i < NREGS; i++) rd_chk("mid_rst_reg", i, 8'h00);
    load(0, 8'h01);
    load(1, 8'h02);
    swap(0, 1);
    rd_chk("post_rst_r0", 0, 8'h02);
    rd_chk("post_rst_r1", 1, 8'h01);

    load(0, 8'hAA);
    load(1, 8'hBB);
    load(2, 8'hCC);
    n_acc = 0;
    pi = 0;
    w = 1'b1; sel_a = pa[0]; sel_b = pb[0];
    for (int t = 0; t < 12; t++) begin
      tick();
      if (step == 3'b001) n_acc++;
      if (!busy) begin
        pi++;
        ld = 1'b0;
        sel_a = pa[pi];
        sel_b = pb[pi];
      end else begin
        ld = 1'b1;
        ld_addr = 3'd0;
        ld_data = 8'hEE;
        sel_a = 3'd3;
        sel_b = 3'd4;
      end
    end
    w = 1'b0;
    ld = 1'b0;
    chk("held_accepts", 32'(n_acc), 32'd3);
    chk("held_busy", 32'(busy), 32'd0);
    rd_chk("held_r0", 0, 8'hAA);
    rd_chk("held_r1", 1, 8'hCC);
    rd_chk("held_r2", 2, 8'hBB);
    rd_chk("held_r3", 3, 8'h00);

    load(3, 8'h33);
    ld = 1'b1; ld_addr = 3'd0; ld_data = 8'h5A;
    w = 1'b1; sel_a = 3'd0; sel_b = 3'd3;
    tick();
    ld = 1'b0;
    w = 1'b0;
    repeat (3) tick();
    rd_chk("same_edge_r0", 0, 8'h33);
    rd_chk("same_edge_r3", 3, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
